// File: rtl/snake_food_ctrl.sv
// snake_food_ctrl
//   Food manager that sits beside the snake logic block. It picks a
//   pseudo-random food cell from a free-running 15-bit LFSR and plots it during
//   the snake controller's food_en window. It also detects when the head lands
//   on the food, grows the length fed back to the snake logic, and keeps the
//   score. Everything freezes once isDead is seen; only rst leaves that state.
//
//   Optional build macro FOOD_TIMEOUT_EN: uneaten food is erased and moved
//   after TIMEOUT_CYC cycles in the armed state.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   head_x/y    in   snake head position (8/7 bits)
//   food_en     in   plot window granted by the snake controller
//   isDead      in   snake dead flag
//   length      out  current snake length (11 bits)
//   food_x/y    out  current food cell
//   x/y         out  plot coordinates, valid while plotEn
//   colour_out  out  plot colour, valid while plotEn
//   plotEn      out  one-cycle pixel write strobe
//   ate         out  one-cycle pulse when food is eaten
//   score       out  foods eaten, wraps at 16 bits
module snake_food_ctrl #(
  parameter int unsigned X_MAX       = 160,
  parameter int unsigned Y_MAX       = 120,
  parameter logic [10:0] INIT_LEN    = 11'd4,
  parameter logic [10:0] GROW        = 11'd1,
  parameter logic [10:0] MAX_LEN     = 11'd2047,
  parameter logic [14:0] SEED        = 15'h1ACE,
  parameter logic [2:0]  FOOD_COLOUR = 3'b010,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  head_x,
  input  logic [6:0]  head_y,
  input  logic        food_en,
  input  logic        isDead,
  output logic [10:0] length,
  output logic [7:0]  food_x,
  output logic [6:0]  food_y,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour_out,
  output logic        plotEn,
  output logic        ate,
  output logic [15:0] score
);

  typedef enum logic [2:0] {
    SPAWN,
    WAIT_DRAW,
    ARMED,
`ifdef FOOD_TIMEOUT_EN
    ERASE,
`endif
    DEAD
  } state_t;

  state_t      state;
  logic [14:0] lfsr;

  logic [7:0]  cand_x;
  logic [6:0]  cand_y;
  logic        cand_ok;
  logic        head_hit;
  logic [11:0] len_sum;
  logic [10:0] len_next;

`ifdef FOOD_TIMEOUT_EN
  logic [23:0] tmo_cnt;
`endif

  always_comb begin
    cand_x   = lfsr[14:7];
    cand_y   = lfsr[6:0];
    cand_ok  = (32'(cand_x) < X_MAX) && (32'(cand_y) < Y_MAX) &&
               !((cand_x == head_x) && (cand_y == head_y));
    head_hit = (head_x == food_x) && (head_y == food_y);
    // One extra bit so the sum can never wrap before the clamp.
    len_sum  = {1'b0, length} + {1'b0, GROW};
    len_next = (len_sum > {1'b0, MAX_LEN}) ? MAX_LEN : len_sum[10:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SPAWN;
      lfsr       <= SEED;
      length     <= INIT_LEN;
      score      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      plotEn     <= 1'b0;
      ate        <= 1'b0;
`ifdef FOOD_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      // LFSR free-runs in every state, including DEAD.
      lfsr   <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
      plotEn <= 1'b0;
      ate    <= 1'b0;

      if (isDead) begin
        // Dead takes priority over any eat or plot this cycle.
        state <= DEAD;
      end else begin
        case (state)
          SPAWN: begin
            if (cand_ok) begin
              food_x <= cand_x;
              food_y <= cand_y;
              state  <= WAIT_DRAW;
            end
          end
          WAIT_DRAW: begin
            if (food_en) begin
              plotEn     <= 1'b1;
              x          <= food_x;
              y          <= food_y;
              colour_out <= FOOD_COLOUR;
              state      <= ARMED;
`ifdef FOOD_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end
          ARMED: begin
            if (head_hit) begin
              ate    <= 1'b1;
              length <= len_next;
              score  <= score + 16'd1;
              state  <= SPAWN;
            end
`ifdef FOOD_TIMEOUT_EN
            else if (tmo_cnt == TIMEOUT_CYC - 24'd1) begin
              state <= ERASE;
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
`endif
          end
`ifdef FOOD_TIMEOUT_EN
          ERASE: begin
            if (food_en) begin
              plotEn     <= 1'b1;
              x          <= food_x;
              y          <= food_y;
              colour_out <= 3'b000;
              state      <= SPAWN;
            end
          end
`endif
          DEAD:    state <= DEAD;
          default: state <= SPAWN;
        endcase
      end
    end
  end

endmodule
